// File: rtl/fpu_result_arbiter.sv
// Collects single-cycle results from the FPU sub-units, buffers one per source,
// and serialises them round-robin onto a single writeback port.
module fpu_result_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 64
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_flush,
  input  logic [NUM_SRC-1:0]               i_src_valid,
  input  logic [NUM_SRC-1:0][DATA_W-1:0]   i_src_data,
  input  logic [NUM_SRC-1:0][4:0]          i_src_dest_reg,
  input  logic [NUM_SRC-1:0][4:0]          i_src_flags,
  input  logic [NUM_SRC-1:0]               i_src_is_int,
  output logic [NUM_SRC-1:0]               o_src_hold,
  output logic                             o_wb_valid,
  input  logic                             i_wb_ready,
  output logic [DATA_W-1:0]                o_wb_data,
  output logic [4:0]                       o_wb_dest_reg,
  output logic [4:0]                       o_wb_flags,
  output logic                             o_wb_is_int,
  output logic                             o_busy,
  output logic                             o_overflow
);

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0]             pending_q;
  logic [NUM_SRC-1:0][DATA_W-1:0] slot_data_q;
  logic [NUM_SRC-1:0][4:0]        slot_dest_q;
  logic [NUM_SRC-1:0][4:0]        slot_flags_q;
  logic [NUM_SRC-1:0]             slot_is_int_q;

  logic              wb_valid_q;
  logic [DATA_W-1:0] wb_data_q;
  logic [4:0]        wb_dest_q;
  logic [4:0]        wb_flags_q;
  logic              wb_is_int_q;
  logic [PTR_W-1:0]  rr_ptr_q;
  logic              overflow_q;

  logic              out_free;
  logic [NUM_SRC-1:0] req;
  logic              grant_any;
  logic [PTR_W-1:0]  grant_idx;
  logic [NUM_SRC-1:0] grant_oh;
  logic [PTR_W-1:0]  next_ptr;
  int                idx;
  logic [NUM_SRC-1:0] slot_load;
  logic [NUM_SRC-1:0] pending_d;
  logic              overflow_set;
  logic [DATA_W-1:0] win_data;
  logic [4:0]        win_dest;
  logic [4:0]        win_flags;
  logic              win_is_int;

  // A pending slot is always older than a same-cycle pulse from that source,
  // so the slot wins the mux and the pulse refills the slot behind it.
  always_comb begin
    out_free     = !wb_valid_q || i_wb_ready;
    req          = (pending_q | i_src_valid) & {NUM_SRC{!i_flush}};
    grant_any    = 1'b0;
    grant_idx    = '0;
    grant_oh     = '0;
    idx          = 0;
    slot_load    = '0;
    pending_d    = '0;
    overflow_set = 1'b0;

    if (out_free) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        idx = int'(rr_ptr_q) + k;
        if (idx >= NUM_SRC) idx = idx - NUM_SRC;
        if (!grant_any && req[idx]) begin
          grant_any = 1'b1;
          grant_idx = PTR_W'(idx);
        end
      end
    end
    if (grant_any) grant_oh[grant_idx] = 1'b1;

    next_ptr = (grant_idx == PTR_W'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;

    for (int i = 0; i < NUM_SRC; i++) begin
      if (!i_flush) begin
        if (i_src_valid[i]) begin
          slot_load[i] = (pending_q[i] == grant_oh[i]);
          pending_d[i] = pending_q[i] | !grant_oh[i];
          if (pending_q[i] && !grant_oh[i]) overflow_set = 1'b1;
        end else begin
          pending_d[i] = pending_q[i] & !grant_oh[i];
        end
      end
    end

    if (pending_q[grant_idx]) begin
      win_data   = slot_data_q[grant_idx];
      win_dest   = slot_dest_q[grant_idx];
      win_flags  = slot_flags_q[grant_idx];
      win_is_int = slot_is_int_q[grant_idx];
    end else begin
      win_data   = i_src_data[grant_idx];
      win_dest   = i_src_dest_reg[grant_idx];
      win_flags  = i_src_flags[grant_idx];
      win_is_int = i_src_is_int[grant_idx];
    end
  end

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (slot_load[i]) begin
        slot_data_q[i]   <= i_src_data[i];
        slot_dest_q[i]   <= i_src_dest_reg[i];
        slot_flags_q[i]  <= i_src_flags[i];
        slot_is_int_q[i] <= i_src_is_int[i];
      end
    end
  end

  // Output register only advances when free, which keeps it stable under stall.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pending_q   <= '0;
      wb_valid_q  <= 1'b0;
      wb_data_q   <= '0;
      wb_dest_q   <= '0;
      wb_flags_q  <= '0;
      wb_is_int_q <= 1'b0;
      rr_ptr_q    <= '0;
      overflow_q  <= 1'b0;
    end else begin
      pending_q <= pending_d;
      if (overflow_set) overflow_q <= 1'b1;
      if (i_flush) begin
        wb_valid_q <= 1'b0;
      end else if (grant_any) begin
        wb_valid_q  <= 1'b1;
        wb_data_q   <= win_data;
        wb_dest_q   <= win_dest;
        wb_flags_q  <= win_flags;
        wb_is_int_q <= win_is_int;
        rr_ptr_q    <= next_ptr;
      end else if (i_wb_ready) begin
        wb_valid_q <= 1'b0;
      end
    end
  end

  assign o_src_hold    = pending_q;
  assign o_wb_valid    = wb_valid_q;
  assign o_wb_data     = wb_data_q;
  assign o_wb_dest_reg = wb_dest_q;
  assign o_wb_flags    = wb_flags_q;
  assign o_wb_is_int   = wb_is_int_q;
  assign o_busy        = (|pending_q) | wb_valid_q;
  assign o_overflow    = overflow_q;

endmodule

// File: tb/tb_fpu_result_arbiter.sv
// Bench for fpu_result_arbiter: directed scenarios then random traffic, all
// checked against a queue-based model of held results per source.
module tb_fpu_result_arbiter;

  localparam int NS = 4;
  localparam int DW = 64;

  logic                  i_clk = 1'b0;
  logic                  i_rst;
  logic                  i_flush;
  logic [NS-1:0]         i_src_valid;
  logic [NS-1:0][DW-1:0] i_src_data;
  logic [NS-1:0][4:0]    i_src_dest_reg;
  logic [NS-1:0][4:0]    i_src_flags;
  logic [NS-1:0]         i_src_is_int;
  logic [NS-1:0]         o_src_hold;
  logic                  o_wb_valid;
  logic                  i_wb_ready;
  logic [DW-1:0]         o_wb_data;
  logic [4:0]            o_wb_dest_reg;
  logic [4:0]            o_wb_flags;
  logic                  o_wb_is_int;
  logic                  o_busy;
  logic                  o_overflow;

  int checks = 0;
  int failures = 0;

  fpu_result_arbiter #(.NUM_SRC(NS), .DATA_W(DW)) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_flush        (i_flush),
    .i_src_valid    (i_src_valid),
    .i_src_data     (i_src_data),
    .i_src_dest_reg (i_src_dest_reg),
    .i_src_flags    (i_src_flags),
    .i_src_is_int   (i_src_is_int),
    .o_src_hold     (o_src_hold),
    .o_wb_valid     (o_wb_valid),
    .i_wb_ready     (i_wb_ready),
    .o_wb_data      (o_wb_data),
    .o_wb_dest_reg  (o_wb_dest_reg),
    .o_wb_flags     (o_wb_flags),
    .o_wb_is_int    (o_wb_is_int),
    .o_busy         (o_busy),
    .o_overflow     (o_overflow)
  );

  always #5 i_clk = ~i_clk;

  // Model: every result not yet written back sits in one list tagged with its
  // source; a source may keep at most one such result, extras are lost.
  typedef struct {
    logic [63:0] data;
    logic [4:0]  dest;
    logic [4:0]  flags;
    logic        is_int;
    int          src;
  } ent_t;

  ent_t held[$];
  ent_t m_out;
  bit   m_out_valid = 0;
  int   m_ptr = 0;
  bit   m_ovf = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelStep();
    ent_t e;
    bit   found;
    bit   first;
    int   s;
    int   j;
    if (i_rst) begin
      held.delete();
      m_out       = '{data: 0, dest: 0, flags: 0, is_int: 0, src: 0};
      m_out_valid = 0;
      m_ptr       = 0;
      m_ovf       = 0;
    end else if (i_flush) begin
      held.delete();
      m_out_valid = 0;
    end else begin
      for (int i = 0; i < NS; i++) begin
        if (i_src_valid[i]) begin
          e = '{data: i_src_data[i], dest: i_src_dest_reg[i], flags: i_src_flags[i],
                is_int: i_src_is_int[i], src: i};
          held.push_back(e);
        end
      end
      if (!m_out_valid || i_wb_ready) begin
        found = 0;
        for (int k = 0; k < NS && !found; k++) begin
          s = (m_ptr + k) % NS;
          for (int q = 0; q < held.size() && !found; q++) begin
            if (held[q].src == s) begin
              m_out = held[q];
              held.delete(q);
              m_ptr = (s + 1) % NS;
              found = 1;
            end
          end
        end
        m_out_valid = found;
      end
      for (int i = 0; i < NS; i++) begin
        first = 1;
        j = 0;
        while (j < held.size()) begin
          if (held[j].src == i) begin
            if (first) begin
              first = 0;
              j++;
            end else begin
              held.delete(j);
              m_ovf = 1;
            end
          end else begin
            j++;
          end
        end
      end
    end
  endtask

  task automatic checkOutput();
    logic [NS-1:0] exp_hold;
    exp_hold = '0;
    foreach (held[q]) exp_hold[held[q].src] = 1'b1;
    chk("wb_valid", {63'd0, o_wb_valid}, {63'd0, m_out_valid});
    if (m_out_valid) begin
      chk("wb_data", o_wb_data, m_out.data);
      chk("wb_dest", {59'd0, o_wb_dest_reg}, {59'd0, m_out.dest});
      chk("wb_flags", {59'd0, o_wb_flags}, {59'd0, m_out.flags});
      chk("wb_is_int", {63'd0, o_wb_is_int}, {63'd0, m_out.is_int});
    end
    chk("src_hold", {60'd0, o_src_hold}, {60'd0, exp_hold});
    chk("busy", {63'd0, o_busy}, {63'd0, (held.size() > 0) || m_out_valid});
    chk("overflow", {63'd0, o_overflow}, {63'd0, m_ovf});
  endtask

  task automatic randomizeSources();
    for (int i = 0; i < NS; i++) begin
      i_src_data[i]     = {$urandom, $urandom};
      i_src_dest_reg[i] = 5'($urandom_range(0, 31));
      i_src_flags[i]    = 5'($urandom_range(0, 31));
      i_src_is_int[i]   = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic applyStimulus(input logic [NS-1:0] v, input logic rdy,
                               input logic fl, input logic rs);
    i_src_valid = v;
    i_wb_ready  = rdy;
    i_flush     = fl;
    i_rst       = rs;
    @(posedge i_clk);
    modelStep();
    #1;
    checkOutput();
  endtask

  initial begin
    i_rst = 1'b1;
    i_flush = 1'b0;
    i_wb_ready = 1'b1;
    i_src_valid = '0;
    randomizeSources();

    $display("[TB] reset");
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b1);
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b1);
    chk("rst_wb_data", o_wb_data, 64'd0);
    chk("rst_wb_dest", {59'd0, o_wb_dest_reg}, 64'd0);

    $display("[TB] single result bypass");
    randomizeSources();
    i_src_data[1] = 64'h3FF0000000000000;
    i_src_dest_reg[1] = 5'd7;
    i_src_flags[1] = 5'h01;
    applyStimulus(4'b0010, 1'b1, 1'b0, 1'b0);
    chk("single_valid", {63'd0, o_wb_valid}, 64'd1);
    chk("single_data", o_wb_data, 64'h3FF0000000000000);
    chk("single_dest", {59'd0, o_wb_dest_reg}, 64'd7);
    chk("single_flags", {59'd0, o_wb_flags}, 64'h01);
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);
    chk("single_gone", {63'd0, o_wb_valid}, 64'd0);

    $display("[TB] simultaneous pulses");
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b1);
    randomizeSources();
    applyStimulus(4'b1101, 1'b1, 1'b0, 1'b0);
    chk("simul_hold_a", {60'd0, o_src_hold}, 64'b1100);
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);
    chk("simul_hold_b", {60'd0, o_src_hold}, 64'b1000);
    for (int c = 0; c < 3; c++) applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);

    $display("[TB] backpressure");
    randomizeSources();
    applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      randomizeSources();
      applyStimulus((c == 2) ? 4'b0010 : 4'b0000, 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);

    $display("[TB] overflow");
    randomizeSources();
    applyStimulus(4'b0010, 1'b0, 1'b0, 1'b0);
    randomizeSources();
    applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0);
    randomizeSources();
    applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0);
    chk("ovf_set", {63'd0, o_overflow}, 64'd1);
    for (int c = 0; c < 4; c++) applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);

    $display("[TB] flush");
    randomizeSources();
    applyStimulus(4'b0111, 1'b0, 1'b0, 1'b0);
    randomizeSources();
    applyStimulus(4'b1000, 1'b0, 1'b1, 1'b0);
    chk("flush_busy", {63'd0, o_busy}, 64'd0);
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);

    $display("[TB] reset mid-stall");
    randomizeSources();
    applyStimulus(4'b0011, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0011, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1);
    chk("rst_mid_all", {o_src_hold, o_wb_valid, o_busy, o_overflow, o_wb_is_int},
        64'd0);
    chk("rst_mid_data", o_wb_data, 64'd0);
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);
    randomizeSources();
    applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0);
    chk("rst_mid_lat", {63'd0, o_wb_valid}, 64'd1);
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);

    $display("[TB] random traffic");
    for (int c = 0; c < 600; c++) begin
      logic [NS-1:0] mask;
      randomizeSources();
      mask = NS'($urandom_range(0, 15)) & NS'($urandom_range(0, 15));
      applyStimulus(mask, 1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 199) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpu_result_arbiter.md
FPU_RESULT_ARBITER -- requirements
Module: fpu_result_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4: number of FPU sub-unit result sources (classify, add, mul, div/sqrt).
REQ-002 SHALL have parameter DATA_W, default 64: result width. Narrower sources are zero-extended by the instantiator.
REQ-003 SHALL have port i_clk, input, 1: clock.
REQ-004 SHALL have port i_rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port i_flush, input, 1: pipeline flush, discards all held results.
REQ-006 SHALL have port i_src_valid, input, NUM_SRC: per-source single-cycle result-valid pulse.
REQ-007 SHALL have port i_src_data, input, NUM_SRC x DATA_W: per-source result.
REQ-008 SHALL have port i_src_dest_reg, input, NUM_SRC x 5: per-source destination register.
REQ-009 SHALL have port i_src_flags, input, NUM_SRC x 5: per-source fflags (NV, DZ, OF, UF, NX).
REQ-010 SHALL have port i_src_is_int, input, NUM_SRC: result targets the integer register file (e.g. classify).
REQ-011 SHALL have port o_src_hold, output, NUM_SRC: source slot occupied; the issuing logic must not start that unit.
REQ-012 SHALL have port o_wb_valid, output, 1: writeback entry valid.
REQ-013 SHALL have port i_wb_ready, input, 1: writeback consumer accepts the entry this cycle.
REQ-014 SHALL have port o_wb_data, output, DATA_W: writeback result.
REQ-015 SHALL have port o_wb_dest_reg, output, 5: writeback destination.
REQ-016 SHALL have port o_wb_flags, output, 5: writeback fflags.
REQ-017 SHALL have port o_wb_is_int, output, 1: writeback target file.
REQ-018 SHALL have port o_busy, output, 1: any slot or the output register is occupied.
REQ-019 SHALL have port o_overflow, output, 1: sticky error, a result was lost.

Function
REQ-020 SHALL provide one holding slot per source, each storing data, dest_reg, flags, is_int and a pending bit.
REQ-021 SHALL capture source i into its slot when i_src_valid[i]=1 and the slot is empty or is granted in the same cycle.
REQ-022 SHALL set o_overflow when i_src_valid[i]=1, slot i is pending and not granted, and SHALL discard the new result. o_overflow holds until reset.
REQ-023 SHALL bypass: a source pulse at cycle N with an empty slot and a free output SHALL appear on o_wb_valid at cycle N+1. This is the minimum latency (1 cycle).
REQ-024 SHALL treat the output register as free when o_wb_valid=0 or i_wb_ready=1.
REQ-025 SHALL, when the output is free, grant one requester from the set (pending slots OR incoming pulses) and load it into the output register.
REQ-026 SHALL arbitrate round-robin:
- search starts at rr_ptr.
- on each grant, rr_ptr := winner+1, modulo NUM_SRC.
- rr_ptr is unchanged when there is no grant.
REQ-027 SHALL clear the granted slot's pending bit in the grant cycle.
REQ-028 SHALL keep o_wb_* stable while o_wb_valid=1 and i_wb_ready=0.
REQ-029 SHALL drive o_src_hold[i] equal to the pending bit of slot i (registered, no combinational path from i_src_valid).
REQ-030 SHALL compute o_busy as OR of all pending bits OR o_wb_valid.
REQ-031 SHALL, on i_flush=1, clear all pending bits and o_wb_valid next cycle. Same-cycle i_src_valid pulses are discarded, and o_overflow and rr_ptr are unchanged.
REQ-032 SHALL give i_rst priority over i_flush.
REQ-033 SHALL never reorder results within a source, and never emit a result twice.

Reset
REQ-034 SHALL, on i_rst=1, clear:
- all pending bits, o_src_hold and o_busy to 0.
- o_wb_valid, o_wb_data, o_wb_dest_reg, o_wb_flags and o_wb_is_int to 0.
- rr_ptr and o_overflow to 0.
REQ-035 SHALL abandon any in-flight result on reset mid-operation, with no output on the cycle after reset deasserts.

Verification
REQ-036 Single result, i_wb_ready=1: src1 pulse, data=0x3FF0000000000000, dest=7, flags=0x01 -> cycle N+1: o_wb_valid=1 with those values; cycle N+2: o_wb_valid=0.
REQ-037 Simultaneous pulses, i_wb_ready=1, rr_ptr=0: src0, src2 and src3 pulse together -> outputs src0, src2, src3 on consecutive cycles; o_src_hold[2] high 1 cycle and o_src_hold[3] high 2 cycles.
REQ-038 Backpressure: i_wb_ready=0 for 5 cycles with one result out -> o_wb_* stable for 5 cycles; a src1 pulse meanwhile is held in its slot and emitted the cycle after ready rises.
REQ-039 Overflow: src0 slot pending and output stalled, second src0 pulse -> o_overflow=1; only the first src0 result is ever emitted.
REQ-040 Flush: two slots pending plus the output valid, i_flush=1 with a same-cycle src3 pulse -> next cycle o_busy=0 and no output afterwards.
REQ-041 Reset mid-stall: pending slots plus o_overflow=1, i_rst=1 for 1 cycle -> all outputs 0; a subsequent src0 pulse is emitted with 1-cycle latency.
